data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder on the far side of the stage-three memory port. It accepts the load/store request that stage three presents (memory control code, ALU-computed address, R1 store data) and serves it from a local word array after a fixed, parameterised latency. While a request is outstanding it holds the pipeline through `mem_stall`. It returns load data with a one-cycle valid pulse.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width; array depth is 2**ADDR_W 16-bit words.
- `LATENCY`, 2: BUSY cycles per access; legal range 1..15.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `halt_sys`  input  1  global halt; freezes all state.
- `req_memc`  input  2  request code: 00 none, 01 load, 10 store, 11 reserved.
- `req_addr`  input  16  word address; only bits [ADDR_W-1:0] are used.
- `req_wdata`  input  16  store data.
- `mem_stall`  output  1  pipeline hold.
- `mem_done`  output  1  one-cycle completion pulse (load or store).
- `rd_valid`  output  1  one-cycle pulse; `rd_data` holds a completed load.
- `rd_data`  output  16  last completed load data.
- `err`  output  1  sticky flag: a reserved code was seen.

## Operation
- FSM states: IDLE, BUSY, DONE. A 4-bit down-counter `cnt` times BUSY.
- IDLE:
  - On an edge with code 01 or 10 and `halt_sys`=0: latch op, address index and write data; load `cnt`=LATENCY-1; go to BUSY.
  - Code 00: stay in IDLE.
  - Code 11: stay in IDLE and set `err`; the request is not accepted.
- BUSY:
  - `cnt`≠0: decrement.
  - `cnt`=0: perform the access at this edge and go to DONE.
    - Store: write the latched data to `mem[idx]`.
    - Load: `rd_data` <= `mem[idx]`.
- DONE: unconditionally go to IDLE. It never accepts a request, because the old request is still on the inputs until this edge advances the pipeline.
- Inputs are ignored outside IDLE. The access uses only the latched copies.
- Address aliasing: upper address bits are discarded, so addresses 0x0105 and 0x0005 hit the same word when ADDR_W=8.
- `halt_sys`=1:
  - FSM, `cnt` and `err` hold.
  - No array write or `rd_data` update occurs.
  - Outputs keep their current decoded values.
- `mem_stall` is combinational: 1 in BUSY, or in IDLE when the code is 01 or 10; otherwise 0. It is 0 in DONE.
- `mem_done` = (state==DONE). `rd_valid` = (state==DONE && latched op==load).
- Array contents are not cleared by reset. A read of a never-written word is undefined.

## Timing
- Reset values:
  - state IDLE, `cnt`=0, `rd_data`=0x0000, `err`=0.
  - Hence `mem_done`=0 and `rd_valid`=0.
  - `mem_stall` = 0 unless a valid code is present on the inputs.
- Request first presented in cycle c (state IDLE):
  - `mem_stall` is high for cycles c..c+LATENCY, i.e. LATENCY+1 cycles.
  - BUSY spans cycles c+1..c+LATENCY.
  - DONE is cycle c+LATENCY+1; `mem_done`, and `rd_valid` for loads, are high only in that cycle.
- A store is committed at the end of cycle c+LATENCY. A load issued afterwards sees the new data.
- Minimum spacing between back-to-back requests: LATENCY+2 cycles (DONE forces one cycle back in IDLE).
- `halt_sys` high for H cycles during a request delays DONE by exactly H cycles.
- Reset asserted mid-request:
  - Immediate return to IDLE; the latched request is discarded.
  - A store not yet committed is lost.
  - No `mem_done` pulse is produced.
- `rd_data` holds its value across stores and idle cycles. It changes only when a load completes.

## Test plan
- Store then load, LATENCY=2: store 0xBEEF to address 0x0005 -> `mem_stall` high 3 cycles, `mem_done` pulse in cycle 4, `rd_valid`=0. Then load address 0x0005 -> `rd_valid` pulse in cycle 4 with `rd_data`=0xBEEF.
- Aliasing, ADDR_W=8: store 0x1234 to 0x0105, then load 0x0005 -> `rd_data`=0x1234.
- Halt during BUSY: with LATENCY=2, assert `halt_sys` for 3 cycles in the first BUSY cycle -> `mem_done` arrives at cycle 7 instead of cycle 4, and `mem_stall` stays high throughout.
- Reserved code: `req_memc`=11 -> `mem_stall`=0 and no `mem_done`. `err`=1 after the next edge and stays 1 through subsequent valid accesses until `rst`.
- Reset mid-store: store 0xAAAA to 0x0010, which already holds 0x5555; pulse `rst` in the BUSY cycle -> `mem_stall`=0 and `mem_done` never pulses. A subsequent load of 0x0010 returns 0x5555.
- LATENCY=1 back-to-back loads: the second request is accepted only in the IDLE cycle after DONE. Each load shows a 2-cycle `mem_stall` and the correct `rd_data`.

Source files
------------

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Serves the stage-three load/store request from a local array of
// 2**ADDR_W 16-bit words after a fixed LATENCY of BUSY cycles. The pipeline
// is held through mem_stall while a request is outstanding. mem_done (and
// rd_valid for loads) pulse in the single DONE cycle that follows.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   halt_sys   global halt; freezes FSM, counter, flag, array and rd_data
//   req_memc   request code: 00 none, 01 load, 10 store, 11 reserved
//   req_addr   word address; only bits [ADDR_W-1:0] are used
//   req_wdata  store data
//   mem_stall  pipeline hold (combinational)
//   mem_done   one-cycle completion pulse for loads and stores
//   rd_valid   one-cycle pulse marking rd_data as a fresh load result
//   rd_data    data of the last completed load
//   err        sticky flag, set when a reserved code is seen in IDLE
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic [1:0]  req_memc,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        mem_stall,
  output logic        mem_done,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        err
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [1:0] MEMC_NONE  = 2'b00;
  localparam logic [1:0] MEMC_LOAD  = 2'b01;
  localparam logic [1:0] MEMC_STORE = 2'b10;
  localparam logic [1:0] MEMC_RSVD  = 2'b11;

  // BUSY lasts cnt+1 cycles, so the counter starts one below LATENCY.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              op_load;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       wdata;
  logic [15:0]       mem [2**ADDR_W];

  logic              req_valid;
  logic              store_commit;

  assign req_valid = (req_memc == MEMC_LOAD) || (req_memc == MEMC_STORE);

  // The access edge: last BUSY cycle, not frozen by halt.
  assign store_commit = (state == ST_BUSY) && (cnt == 4'd0) && !halt_sys && !op_load;

  // Upper address bits are deliberately discarded (address aliasing).
  if (ADDR_W < 16) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[15:ADDR_W];
  end

  // Request FSM, BUSY counter, latched request, load result and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      op_load <= 1'b0;
      idx     <= '0;
      wdata   <= 16'h0000;
      rd_data <= 16'h0000;
      err     <= 1'b0;
    end else if (!halt_sys) begin
      case (state)
        ST_IDLE: begin
          case (req_memc)
            MEMC_LOAD, MEMC_STORE: begin
              state   <= ST_BUSY;
              cnt     <= CNT_INIT;
              op_load <= (req_memc == MEMC_LOAD);
              idx     <= req_addr[ADDR_W-1:0];
              wdata   <= req_wdata;
            end
            // A reserved code is flagged but never accepted.
            MEMC_RSVD: err   <= 1'b1;
            MEMC_NONE: state <= ST_IDLE;
            default:   state <= ST_IDLE;
          endcase
        end
        ST_BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= ST_DONE;
            if (op_load) begin
              rd_data <= mem[idx];
            end
          end
        end
        // The old request is still on the inputs here; never accept it.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Word array: not reset, written only on the store commit edge.
  always_ff @(posedge clk) begin
    if (store_commit) begin
      mem[idx] <= wdata;
    end
  end

  assign mem_stall = (state == ST_BUSY) || ((state == ST_IDLE) && req_valid);
  assign mem_done  = (state == ST_DONE);
  assign rd_valid  = (state == ST_DONE) && op_load;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  // Instance a: LATENCY=2, instance b: LATENCY=1
  logic        a_halt, b_halt;
  logic [1:0]  a_memc, b_memc;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_stall, a_done, a_valid, a_err;
  logic        b_stall, b_done, b_valid, b_err;
  logic [15:0] a_rd, b_rd;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .halt_sys(a_halt), .req_memc(a_memc),
    .req_addr(a_addr), .req_wdata(a_wdata), .mem_stall(a_stall),
    .mem_done(a_done), .rd_valid(a_valid), .rd_data(a_rd), .err(a_err)
  );

  data_mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .halt_sys(b_halt), .req_memc(b_memc),
    .req_addr(b_addr), .req_wdata(b_wdata), .mem_stall(b_stall),
    .mem_done(b_done), .rd_valid(b_valid), .rd_data(b_rd), .err(b_err)
  );

  // Present one request for n cycles (starting just after a rising edge),
  // recording per-cycle stall/done/valid bits and rd_data of the last cycle.
  task automatic run_req(input bit sel, input logic [1:0] code,
                         input logic [15:0] addr, input logic [15:0] data,
                         input int halt_at, input int halt_len, input int n,
                         output logic [15:0] st, output logic [15:0] dn,
                         output logic [15:0] vl, output logic [15:0] last_rd);
    st = 16'h0000; dn = 16'h0000; vl = 16'h0000; last_rd = 16'h0000;
    for (int i = 0; i < n; i++) begin
      logic h;
      h = (i >= halt_at) && (i < halt_at + halt_len);
      if (!sel) begin
        a_memc = code; a_addr = addr; a_wdata = data; a_halt = h;
      end else begin
        b_memc = code; b_addr = addr; b_wdata = data; b_halt = h;
      end
      #2;
      if (!sel) begin
        st[i] = a_stall; dn[i] = a_done; vl[i] = a_valid; last_rd = a_rd;
      end else begin
        st[i] = b_stall; dn[i] = b_done; vl[i] = b_valid; last_rd = b_rd;
      end
      @(posedge clk); #1;
    end
    a_memc = 2'b00; a_halt = 1'b0;
    b_memc = 2'b00; b_halt = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_halt = 1'b0; a_memc = 2'b00; a_addr = 16'h0000; a_wdata = 16'h0000;
    b_halt = 1'b0; b_memc = 2'b00; b_addr = 16'h0000; b_wdata = 16'h0000;
    #3;
    n_cmp++;
    if ({a_stall, a_done, a_valid, a_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got stall/done/valid/err=%b want 0000", {a_stall, a_done, a_valid, a_err});
    end
    n_cmp++;
    if (a_rd !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %h want 0000", a_rd);
    end
    n_cmp++;
    if ({b_stall, b_done, b_valid, b_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags_lat1: got %b want 0000", {b_stall, b_done, b_valid, b_err});
    end
    a_memc = 2'b01;
    #1;
    n_cmp++;
    if (a_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall_valid_code: got %b want 1", a_stall);
    end
    a_memc = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({a_stall, a_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got stall/done=%b want 00", {a_stall, a_done});
    end
  endtask

  task automatic test_store_load;
    logic [15:0] st, dn, vl, rd;
    run_req(1'b0, 2'b10, 16'h0005, 16'hBEEF, 99, 0, 4, st, dn, vl, rd);
    n_cmp++;
    if ({st[3:0], dn[3:0], vl[3:0]} !== {4'b0111, 4'b1000, 4'b0000}) begin
      n_fail++;
      $display("FAIL store_timing: got stall=%b done=%b valid=%b want 0111 1000 0000", st[3:0], dn[3:0], vl[3:0]);
    end
    n_cmp++;
    if (rd !== 16'h0000) begin
      n_fail++;
      $display("FAIL store_keeps_rd: got %h want 0000", rd);
    end
    run_req(1'b0, 2'b01, 16'h0005, 16'h0000, 99, 0, 4, st, dn, vl, rd);
    n_cmp++;
    if ({st[3:0], dn[3:0], vl[3:0]} !== {4'b0111, 4'b1000, 4'b1000}) begin
      n_fail++;
      $display("FAIL load_timing: got stall=%b done=%b valid=%b want 0111 1000 1000", st[3:0], dn[3:0], vl[3:0]);
    end
    n_cmp++;
    if (rd !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL load_data: got %h want beef", rd);
    end
  endtask

  task automatic test_alias;
    logic [15:0] st, dn, vl, rd;
    run_req(1'b0, 2'b10, 16'h0105, 16'h1234, 99, 0, 4, st, dn, vl, rd);
    run_req(1'b0, 2'b01, 16'h0005, 16'h0000, 99, 0, 4, st, dn, vl, rd);
    n_cmp++;
    if (rd !== 16'h1234 || vl[3:0] !== 4'b1000) begin
      n_fail++;
      $display("FAIL alias_load: got data=%h valid=%b want 1234 1000", rd, vl[3:0]);
    end
  endtask

  task automatic test_halt;
    logic [15:0] st, dn, vl, rd;
    run_req(1'b0, 2'b10, 16'h0007, 16'hC0DE, 99, 0, 4, st, dn, vl, rd);
    // Halt for the three cycles starting at the first BUSY cycle.
    run_req(1'b0, 2'b01, 16'h0007, 16'h0000, 1, 3, 7, st, dn, vl, rd);
    n_cmp++;
    if (st[6:0] !== 7'b0111111) begin
      n_fail++;
      $display("FAIL halt_stall: got %b want 0111111", st[6:0]);
    end
    n_cmp++;
    if (dn[6:0] !== 7'b1000000 || vl[6:0] !== 7'b1000000) begin
      n_fail++;
      $display("FAIL halt_done: got done=%b valid=%b want 1000000 1000000", dn[6:0], vl[6:0]);
    end
    n_cmp++;
    if (rd !== 16'hC0DE) begin
      n_fail++;
      $display("FAIL halt_data: got %h want c0de", rd);
    end
  endtask

  task automatic test_reserved;
    logic [15:0] st, dn, vl, rd;
    n_cmp++;
    if (a_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_before: got %b want 0", a_err);
    end
    run_req(1'b0, 2'b11, 16'h0005, 16'h0000, 99, 0, 2, st, dn, vl, rd);
    n_cmp++;
    if ({st[1:0], dn[1:0]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rsvd_no_accept: got stall=%b done=%b want 00 00", st[1:0], dn[1:0]);
    end
    n_cmp++;
    if (a_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rsvd_err_set: got %b want 1", a_err);
    end
    run_req(1'b0, 2'b01, 16'h0005, 16'h0000, 99, 0, 4, st, dn, vl, rd);
    n_cmp++;
    if (a_err !== 1'b1 || dn[3:0] !== 4'b1000 || rd !== 16'h1234) begin
      n_fail++;
      $display("FAIL rsvd_err_sticky: got err=%b done=%b data=%h want 1 1000 1234", a_err, dn[3:0], rd);
    end
  endtask

  task automatic test_reset_mid_store;
    logic [15:0] st, dn, vl, rd;
    logic seen;
    run_req(1'b0, 2'b10, 16'h0010, 16'h5555, 99, 0, 4, st, dn, vl, rd);
    a_memc = 2'b10; a_addr = 16'h0010; a_wdata = 16'hAAAA;
    #2;
    n_cmp++;
    if (a_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_accept: got stall=%b want 1", a_stall);
    end
    @(posedge clk); #1;
    rst = 1'b1; a_memc = 2'b00;
    #1;
    n_cmp++;
    if ({a_stall, a_done, a_err} !== 3'b000 || a_rd !== 16'h0000) begin
      n_fail++;
      $display("FAIL rstmid_state: got stall/done/err=%b rd=%h want 000 0000", {a_stall, a_done, a_err}, a_rd);
    end
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen = seen | a_done;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_done: got done seen=%b want 0", seen);
    end
    run_req(1'b0, 2'b01, 16'h0010, 16'h0000, 99, 0, 4, st, dn, vl, rd);
    n_cmp++;
    if (rd !== 16'h5555 || vl[3:0] !== 4'b1000) begin
      n_fail++;
      $display("FAIL rstmid_store_lost: got data=%h valid=%b want 5555 1000", rd, vl[3:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] st, dn, vl, rd;
    run_req(1'b1, 2'b10, 16'h0020, 16'h0A0A, 99, 0, 3, st, dn, vl, rd);
    n_cmp++;
    if ({st[2:0], dn[2:0], vl[2:0]} !== {3'b011, 3'b100, 3'b000}) begin
      n_fail++;
      $display("FAIL b2b_store_timing: got stall=%b done=%b valid=%b want 011 100 000", st[2:0], dn[2:0], vl[2:0]);
    end
    run_req(1'b1, 2'b10, 16'h0021, 16'h0B0B, 99, 0, 3, st, dn, vl, rd);
    run_req(1'b1, 2'b01, 16'h0020, 16'h0000, 99, 0, 3, st, dn, vl, rd);
    n_cmp++;
    if ({st[2:0], dn[2:0], vl[2:0]} !== {3'b011, 3'b100, 3'b100} || rd !== 16'h0A0A) begin
      n_fail++;
      $display("FAIL b2b_load1: got stall=%b done=%b valid=%b data=%h want 011 100 100 0a0a", st[2:0], dn[2:0], vl[2:0], rd);
    end
    run_req(1'b1, 2'b01, 16'h0021, 16'h0000, 99, 0, 3, st, dn, vl, rd);
    n_cmp++;
    if ({st[2:0], dn[2:0], vl[2:0]} !== {3'b011, 3'b100, 3'b100} || rd !== 16'h0B0B) begin
      n_fail++;
      $display("FAIL b2b_load2: got stall=%b done=%b valid=%b data=%h want 011 100 100 0b0b", st[2:0], dn[2:0], vl[2:0], rd);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_alias();
    test_halt();
    test_reserved();
    test_reset_mid_store();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
